// File: rtl/video_timing_probe.sv
// video_timing_probe: passive checker for the core video output.
// Measures line/frame geometry and sync polarity, flags stable timing.
//
// Ports:
//   clk_sys, reset (async, active high), ce_pix (pixel enable)
//   hs, vs        : syncs, either polarity
//   hblank/vblank : active-high blanking
//   h_total, h_active, v_total, v_active : published measurements
//   hs_pol, vs_pol : detected sync polarity (1 = active high)
//   frame_strobe, changed : 1-cycle publish / difference pulses
//   locked : timing stable, overflow : sticky counter saturation
module video_timing_probe #(
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             hs,
  input  logic             vs,
  input  logic             hblank,
  input  logic             vblank,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic             frame_strobe,
  output logic             changed,
  output logic             locked,
  output logic             overflow
);

  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [SW-1:0] SF = SW'(STABLE_FRAMES);
  localparam logic [SW-1:0] SONE = SW'(1);

  function automatic logic [CNT_W-1:0] inc_sat(
    input logic [CNT_W-1:0] v
  );
    return (v == MAX) ? v : v + ONE;
  endfunction

  logic             de;
  logic             hs_q, vs_q, de_q;
  logic             pol_known, armed, pub_pend;
  logic             has_pub, line_de;
  logic [CNT_W-1:0] hcnt, hde, vcnt, vact;
  logic [CNT_W-1:0] cur_h_total, cur_h_active;
  logic [CNT_W-1:0] cur_v_total, cur_v_active;
  logic [SW-1:0]    stable_cnt, stable_inc;

  logic de_rise, de_fall, hs_lead, vs_lead;
  logic pol_chg, line_seen, sat_any, same_set;
  logic [CNT_W-1:0] vcnt_nx, vact_nx;

  assign de = ~(hblank | vblank);

  always_comb begin
    de_rise = ce_pix & de & ~de_q;
    de_fall = ce_pix & ~de & de_q;
    // Edges only count as sync edges once polarity is known.
    hs_lead = ce_pix & pol_known
            & (hs == hs_pol) & (hs_q != hs_pol);
    vs_lead = ce_pix & pol_known
            & (vs == vs_pol) & (vs_q != vs_pol);
    pol_chg = de_rise & pol_known
            & ((hs_pol != ~hs) | (vs_pol != ~vs));
    line_seen = line_de | (ce_pix & de);
    // The hs update lands first so a coincident vs edge
    // includes the closing line.
    vcnt_nx = hs_lead ? inc_sat(vcnt) : vcnt;
    vact_nx = (hs_lead & line_seen) ? inc_sat(vact) : vact;
    sat_any = (ce_pix & (hcnt == MAX))
            | (ce_pix & de & (hde == MAX))
            | (hs_lead & (vcnt == MAX))
            | (hs_lead & line_seen & (vact == MAX));
    same_set = (cur_h_total == h_total)
             & (cur_h_active == h_active)
             & (cur_v_total == v_total)
             & (cur_v_active == v_active);
    stable_inc = (stable_cnt == SF) ? SF : stable_cnt + SONE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      pol_known    <= 1'b0;
      armed        <= 1'b0;
      pub_pend     <= 1'b0;
      has_pub      <= 1'b0;
      line_de      <= 1'b0;
      hcnt         <= '0;
      hde          <= '0;
      vcnt         <= '0;
      vact         <= '0;
      cur_h_total  <= '0;
      cur_h_active <= '0;
      cur_v_total  <= '0;
      cur_v_active <= '0;
      stable_cnt   <= '0;
      h_total      <= '0;
      h_active     <= '0;
      v_total      <= '0;
      v_active     <= '0;
      hs_pol       <= 1'b0;
      vs_pol       <= 1'b0;
      frame_strobe <= 1'b0;
      changed      <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      changed      <= 1'b0;
      pub_pend     <= 1'b0;
      if (ce_pix) begin
        hs_q <= hs;
        vs_q <= vs;
        de_q <= de;
        hcnt <= hs_lead ? '0 : inc_sat(hcnt);
        if (de_fall) begin
          cur_h_active <= hde;
          hde          <= '0;
        end else if (de) begin
          hde <= inc_sat(hde);
        end
        if (hs_lead) begin
          cur_h_total <= inc_sat(hcnt);
          line_de     <= 1'b0;
        end else if (de) begin
          line_de <= 1'b1;
        end
        if (vs_lead) begin
          cur_v_total  <= vcnt_nx;
          cur_v_active <= vact_nx;
          vcnt         <= '0;
          vact         <= '0;
          armed        <= 1'b1;
          // The first vs edge only arms measurement.
          pub_pend     <= armed;
        end else begin
          vcnt <= vcnt_nx;
          vact <= vact_nx;
        end
        if (de_rise) begin
          hs_pol    <= ~hs;
          vs_pol    <= ~vs;
          pol_known <= 1'b1;
        end
      end
      if (pub_pend) begin
        h_total      <= cur_h_total;
        h_active     <= cur_h_active;
        v_total      <= cur_v_total;
        v_active     <= cur_v_active;
        frame_strobe <= 1'b1;
        has_pub      <= 1'b1;
        if (has_pub & same_set) begin
          stable_cnt <= stable_inc;
          if (stable_inc == SF)
            locked <= 1'b1;
        end else begin
          stable_cnt <= '0;
          locked     <= 1'b0;
          changed    <= has_pub;
        end
      end
      if (pol_chg) begin
        stable_cnt <= '0;
        locked     <= 1'b0;
      end
      overflow <= overflow | sat_any;
      if (overflow | sat_any)
        locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_probe.sv
// tb_video_timing_probe: directed scenarios for video_timing_probe.
// Uses scaled-down timings (40x12, 44x12, 300x8) to keep runs short.
module tb_video_timing_probe;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ce_pix = 1'b0;
  logic hs = 1'b1;
  logic vs = 1'b1;
  logic hblank = 1'b1;
  logic vblank = 1'b1;

  logic [11:0] h_total, h_active, v_total, v_active;
  logic hs_pol, vs_pol, frame_strobe, changed, locked, overflow;

  logic [7:0] h_total8, h_active8, v_total8, v_active8;
  logic hs_pol8, vs_pol8, frame_strobe8, changed8;
  logic locked8, overflow8;

  logic pol_exp = 1'b0;
  int checks = 0;
  int failures = 0;

  int strobes = 0;
  int changes = 0;
  int wide = 0;
  int lat_err = 0;
  int lock8_cycles = 0;
  logic strobe_prev = 1'b0;
  logic vs_prev_tb = 1'b1;
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  logic lead_now;

  always #5 clk_sys = ~clk_sys;

  video_timing_probe #(.CNT_W(12), .STABLE_FRAMES(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank),
    .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
    .frame_strobe(frame_strobe), .changed(changed),
    .locked(locked), .overflow(overflow)
  );

  video_timing_probe #(.CNT_W(8), .STABLE_FRAMES(2)) dut8 (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank),
    .h_total(h_total8), .h_active(h_active8),
    .v_total(v_total8), .v_active(v_active8),
    .hs_pol(hs_pol8), .vs_pol(vs_pol8),
    .frame_strobe(frame_strobe8), .changed(changed8),
    .locked(locked8), .overflow(overflow8)
  );

  // Pulse monitor; a strobe must follow a vs leading-edge
  // sample by exactly one clk_sys cycle.
  always @(negedge clk_sys) begin
    if (frame_strobe && strobe_prev) wide++;
    strobe_prev = frame_strobe;
    if (frame_strobe) strobes++;
    if (changed) changes++;
    if (frame_strobe && !d2) lat_err++;
    if (locked8) lock8_cycles++;
    lead_now = ce_pix && (vs == pol_exp) && (vs_prev_tb != pol_exp);
    d2 = d1;
    d1 = lead_now;
    if (ce_pix) vs_prev_tb = vs;
  end

  task automatic drive(input int htot, input int hact,
                       input int vtot, input int vact,
                       input logic pol, input int div,
                       input int npix);
    int x, y, hs0, vr;
    logic von;
    hs0 = hact + 2;
    vr = vact + 1;
    for (int p = 0; p < npix; p++) begin
      x = p % htot;
      y = (p / htot) % vtot;
      von = ((y > vr) || (y == vr && x >= hs0))
         && ((y < vr + 2) || (y == vr + 2 && x < hs0));
      @(posedge clk_sys); #1;
      hblank = (x >= hact);
      vblank = (y >= vact);
      hs = (x >= hs0 && x < hs0 + 4) ? pol : ~pol;
      vs = von ? pol : ~pol;
      ce_pix = 1'b1;
      for (int k = 1; k < div; k++) begin
        @(posedge clk_sys); #1;
        ce_pix = 1'b0;
      end
    end
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    ce_pix = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({h_total, h_active, v_total, v_active, hs_pol, vs_pol,
         frame_strobe, changed, locked, overflow} !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
        {h_total, h_active, v_total, v_active});
    end
    checks++;
    if ({h_total8, h_active8, v_total8, v_active8, hs_pol8,
         vs_pol8, frame_strobe8, changed8, locked8,
         overflow8} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs8 got=%h exp=0",
        {h_total8, h_active8, v_total8, v_active8});
    end
  endtask

  task automatic test_basic;
    do_reset();
    pol_exp = 1'b0;
    drive(40, 32, 12, 8, 1'b0, 1, 3 * 480);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_lock got=%b exp=0", locked);
    end
    drive(40, 32, 12, 8, 1'b0, 1, 480);
    checks++;
    if ({h_total, h_active, v_total, v_active} !==
        {12'd40, 12'd32, 12'd12, 12'd8}) begin
      failures++;
      $display("FAIL basic_counts got=%0d,%0d,%0d,%0d exp=40,32,12,8",
        h_total, h_active, v_total, v_active);
    end
    checks++;
    if ({hs_pol, vs_pol} !== 2'b00) begin
      failures++;
      $display("FAIL basic_pol got=%b%b exp=00", hs_pol, vs_pol);
    end
    checks++;
    if ({locked, overflow} !== 2'b10) begin
      failures++;
      $display("FAIL basic_lock got=%b%b exp=10", locked, overflow);
    end
  endtask

  task automatic test_change;
    int c0;
    c0 = changes;
    drive(44, 36, 12, 8, 1'b0, 1, 528);
    checks++;
    if (changes - c0 != 1) begin
      failures++;
      $display("FAIL change_pulse got=%0d exp=1", changes - c0);
    end
    checks++;
    if ({locked, h_total} !== {1'b0, 12'd44}) begin
      failures++;
      $display("FAIL change_unlock got=%b,%0d exp=0,44",
        locked, h_total);
    end
    drive(44, 36, 12, 8, 1'b0, 1, 2 * 528);
    checks++;
    if ({h_total, h_active, v_total, v_active} !==
        {12'd44, 12'd36, 12'd12, 12'd8}) begin
      failures++;
      $display("FAIL change_counts got=%0d,%0d,%0d,%0d exp=44,36,12,8",
        h_total, h_active, v_total, v_active);
    end
    checks++;
    if (locked !== 1'b1 || changes - c0 != 1) begin
      failures++;
      $display("FAIL change_relock got=%b,%0d exp=1,1",
        locked, changes - c0);
    end
  endtask

  task automatic test_reset_midline;
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_lock got=%b exp=1", locked);
    end
    drive(40, 32, 12, 8, 1'b0, 1, 20);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({h_total, h_active, v_total, v_active, hs_pol, vs_pol,
         frame_strobe, changed, locked, overflow} !== 54'd0) begin
      failures++;
      $display("FAIL midrst_clear got=%h,%b exp=0",
        {h_total, h_active, v_total, v_active}, locked);
    end
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    drive(40, 32, 12, 8, 1'b0, 1, 4 * 480);
    checks++;
    if ({h_total, h_active, v_total, v_active, locked} !==
        {12'd40, 12'd32, 12'd12, 12'd8, 1'b1}) begin
      failures++;
      $display("FAIL midrst_relock got=%0d,%0d,%0d,%0d,%b exp=40,32,12,8,1",
        h_total, h_active, v_total, v_active, locked);
    end
  endtask

  task automatic test_pol_high;
    int s0, w0, l0;
    do_reset();
    s0 = strobes;
    w0 = wide;
    l0 = lat_err;
    pol_exp = 1'b1;
    drive(40, 32, 12, 8, 1'b1, 1, 4 * 480);
    checks++;
    if ({h_total, h_active, v_total, v_active} !==
        {12'd40, 12'd32, 12'd12, 12'd8}) begin
      failures++;
      $display("FAIL polhi_counts got=%0d,%0d,%0d,%0d exp=40,32,12,8",
        h_total, h_active, v_total, v_active);
    end
    checks++;
    if ({hs_pol, vs_pol, locked} !== 3'b111) begin
      failures++;
      $display("FAIL polhi_pol got=%b%b%b exp=111",
        hs_pol, vs_pol, locked);
    end
    checks++;
    if (strobes - s0 != 3) begin
      failures++;
      $display("FAIL polhi_strobes got=%0d exp=3", strobes - s0);
    end
    checks++;
    if (wide - w0 != 0 || lat_err - l0 != 0) begin
      failures++;
      $display("FAIL polhi_strobe_shape got=%0d,%0d exp=0,0",
        wide - w0, lat_err - l0);
    end
  endtask

  task automatic test_ce_div;
    int l0;
    do_reset();
    l0 = lat_err;
    pol_exp = 1'b0;
    drive(40, 32, 12, 8, 1'b0, 4, 4 * 480);
    checks++;
    if ({h_total, h_active, v_total, v_active, locked} !==
        {12'd40, 12'd32, 12'd12, 12'd8, 1'b1}) begin
      failures++;
      $display("FAIL cediv_counts got=%0d,%0d,%0d,%0d,%b exp=40,32,12,8,1",
        h_total, h_active, v_total, v_active, locked);
    end
    checks++;
    if (lat_err - l0 != 0) begin
      failures++;
      $display("FAIL cediv_latency got=%0d exp=0", lat_err - l0);
    end
  endtask

  task automatic test_overflow;
    int k0;
    do_reset();
    k0 = lock8_cycles;
    pol_exp = 1'b0;
    drive(300, 200, 8, 4, 1'b0, 1, 2400);
    checks++;
    if (overflow8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", overflow8);
    end
    drive(300, 200, 8, 4, 1'b0, 1, 3 * 2400);
    checks++;
    if ({overflow8, locked8} !== 2'b10) begin
      failures++;
      $display("FAIL ovf_sticky got=%b%b exp=10", overflow8, locked8);
    end
    checks++;
    if (lock8_cycles - k0 != 0) begin
      failures++;
      $display("FAIL ovf_lock_seen got=%0d exp=0", lock8_cycles - k0);
    end
    checks++;
    if ({h_total, h_active, v_total, v_active} !==
        {12'd300, 12'd200, 12'd8, 12'd4}) begin
      failures++;
      $display("FAIL ovf_wide_counts got=%0d,%0d,%0d,%0d exp=300,200,8,4",
        h_total, h_active, v_total, v_active);
    end
    checks++;
    if ({overflow, locked} !== 2'b01) begin
      failures++;
      $display("FAIL ovf_wide_lock got=%b%b exp=01", overflow, locked);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_reset_midline();
    test_pol_high();
    test_ce_div();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
